key_event_queue: RTL

- Sits directly downstream of the matrix-key scanner/debouncer.
- Turns the 16 debounced key levels into discrete key-press events. Each event is a 4-bit key code.
- Events are queued in a small FIFO and delivered to the consumer (display/CPU logic) over a valid/ready handshake.
- Presses are never silently dropped. A lost event raises a sticky overflow flag.

---
 rtl/key_pkg.sv | 25 ++
 rtl/key_evt_fifo.sv | 56 +++++
 rtl/key_event_queue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the key event queue: key codes, queued event
// layout and the fixed-priority lowest-index picker.
package key_pkg;

    localparam int NKEYS = 16;
    localparam int KEY_W = 4;

    typedef logic [KEY_W-1:0] key_code_t;

    // "release" is a reserved word, hence is_release.
    typedef struct packed {
        logic      is_release;
        key_code_t code;
    } key_evt_t;

    function automatic key_code_t lowest_set_idx(input logic [NKEYS-1:0] mask);
        key_code_t idx;
        idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (mask[i]) idx = key_code_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Small synchronous FIFO holding queued key events; head is presented
// combinationally so a pop needs no extra latency.
module key_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO refuses a push even when the head is leaving this cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced key levels into queued press events (and release events when
// KEY_RELEASE_EVT_EN is defined) delivered over a valid/ready handshake.
module key_event_queue
    import key_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sync_clk,
    input  logic [15:0]            btn,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [3:0]             evt_code,
    output logic                   evt_release,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [NKEYS-1:0]       btn_sync [SYNC_STAGES];
    logic                   sclk_d;
    logic                   sclk_s;
    logic [NKEYS-1:0]       btn_s;
    logic                   frame;

    logic [NKEYS-1:0] snapshot;
    logic [NKEYS-1:0] pending;
    logic [NKEYS-1:0] pending_nxt;
    logic [NKEYS-1:0] press;
    logic [NKEYS-1:0] press_clr;
    logic [NKEYS-1:0] press_left;
    logic             grant;
    key_code_t        grant_code;
    logic             lost;
    logic             fifo_full;
    logic             fifo_empty;

`ifdef KEY_RELEASE_EVT_EN
    logic [NKEYS-1:0] pending_rel;
    logic [NKEYS-1:0] pending_rel_nxt;
    logic [NKEYS-1:0] rel_edge;
    logic [NKEYS-1:0] rel_clr;
    logic [NKEYS-1:0] rel_left;
    logic             grant_rel;
`endif

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign btn_s  = btn_sync[SYNC_STAGES-1];
    assign frame  = sclk_d & ~sclk_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            sclk_d    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) btn_sync[i] <= '0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sync_clk};
            sclk_d      <= sclk_s;
            btn_sync[0] <= btn;
            for (int i = 1; i < SYNC_STAGES; i++) btn_sync[i] <= btn_sync[i-1];
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        press      = btn_s & ~snapshot;
        grant      = 1'b0;
        grant_code = '0;
        press_clr  = '0;
`ifdef KEY_RELEASE_EVT_EN
        rel_edge   = ~btn_s & snapshot;
        grant_rel  = 1'b0;
        rel_clr    = '0;
`endif
        if (!fifo_full) begin
            if (pending != '0) begin
                grant      = 1'b1;
                grant_code = lowest_set_idx(pending);
                press_clr  = NKEYS'(1) << grant_code;
            end
`ifdef KEY_RELEASE_EVT_EN
            else if (pending_rel != '0) begin
                grant      = 1'b1;
                grant_rel  = 1'b1;
                grant_code = lowest_set_idx(pending_rel);
                rel_clr    = NKEYS'(1) << grant_code;
            end
`endif
        end
        // A key being pushed this cycle is no longer pending, so re-pressing it is not a loss.
        press_left  = pending & ~press_clr;
        lost        = frame && ((press & press_left) != '0);
        pending_nxt = frame ? (press_left | press) : press_left;
`ifdef KEY_RELEASE_EVT_EN
        rel_left        = pending_rel & ~rel_clr;
        lost            = lost || (frame && ((rel_edge & rel_left) != '0));
        pending_rel_nxt = frame ? (rel_left | rel_edge) : rel_left;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot <= '0;
            pending  <= '0;
            overflow <= 1'b0;
`ifdef KEY_RELEASE_EVT_EN
            pending_rel <= '0;
`endif
        end else begin
            pending <= pending_nxt;
            if (frame) snapshot <= btn_s;
            if (lost)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
`ifdef KEY_RELEASE_EVT_EN
            pending_rel <= pending_rel_nxt;
`endif
        end
    end

    assign evt_valid = !fifo_empty;

`ifdef KEY_RELEASE_EVT_EN
    key_evt_t push_evt;
    key_evt_t head_evt;

    assign push_evt = '{is_release: grant_rel, code: grant_code};

    key_evt_fifo #(.DEPTH(DEPTH), .WIDTH($bits(key_evt_t))) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant),
        .push_data (push_evt),
        .pop       (evt_valid && evt_ready),
        .head      (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (evt_count)
    );

    assign evt_code    = head_evt.code;
    assign evt_release = head_evt.is_release;
`else
    key_code_t head_code;

    key_evt_fifo #(.DEPTH(DEPTH), .WIDTH(KEY_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant),
        .push_data (grant_code),
        .pop       (evt_valid && evt_ready),
        .head      (head_code),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (evt_count)
    );

    assign evt_code    = head_code;
    assign evt_release = 1'b0;
`endif

endmodule
